// File: rtl/rv64if_pkg.sv
// rv64if_pkg: shared state encoding, NOP constant and address-legality helpers.
package rv64if_pkg;
  typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
  function automatic logic inst_legal(input logic [63:0] a, input logic [63:0] depth);
    return a[1:0] == 2'b00 && (a >> 2) < depth;
  endfunction
  // Bound check on the offset so base+size can never wrap.
  function automatic logic data_legal(input logic [63:0] a, input logic [63:0] base, input logic [63:0] depth);
    logic [63:0] off;
    off = a - base;
    return a[2:0] == 3'b000 && a >= base && (off >> 3) < depth;
  endfunction
endpackage

// File: rtl/rv64if_sp_ram.sv
// rv64if_sp_ram: single-write-port array with asynchronous read.
module rv64if_sp_ram #(
  parameter int W = 32,
  parameter int DEPTH = 1024,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/rv64if_mem_responder.sv
// rv64if_mem_responder: IMEM/DMEM responder with DMEM clear, program loader,
// core reset hold-off and first-fault capture.
module rv64if_mem_responder
  import rv64if_pkg::*;
#(
  parameter int IMEM_DEPTH = 1024,
  parameter int DMEM_DEPTH = 512,
  parameter logic [63:0] DMEM_BASE = 64'h0000_0000_0001_0000
) (
  input  logic        in_Clk,
  input  logic        Rst,
  input  logic [63:0] in_inst_addr,
  output logic [31:0] out_inst,
  input  logic [63:0] in_addr,
  input  logic [63:0] in_wr_data,
  input  logic        in_DM_wr_en,
  output logic [63:0] out_DM_data,
  input  logic        in_ld_valid,
  input  logic [31:0] in_ld_data,
  input  logic        in_ld_last,
  output logic        out_ld_ready,
  output logic        out_core_Rst_N,
  output logic        out_fault,
  output logic [63:0] out_fault_addr,
  output logic        out_ld_overflow
);
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);
  state_t state, state_n;
  logic [DAW-1:0] clr_ptr, d_waddr;
  logic [IAW-1:0] ld_ptr;
  logic [63:0] d_off, d_rdata, d_wdata;
  logic [31:0] i_rdata;
  logic run, clearing, i_ok, d_ok, ld_acc, ld_end, f_fetch, f_wr, d_we;
  assign run = state == RUN;
  assign clearing = state == CLEAR;
  assign i_ok = inst_legal(in_inst_addr, 64'(IMEM_DEPTH));
  assign d_ok = data_legal(in_addr, DMEM_BASE, 64'(DMEM_DEPTH));
  assign d_off = in_addr - DMEM_BASE;
  assign ld_acc = state == LOAD && in_ld_valid;
  assign ld_end = ld_ptr == IAW'(IMEM_DEPTH - 1);
  assign f_fetch = run && !i_ok;
  assign f_wr = run && in_DM_wr_en && !d_ok;
  assign out_ld_ready = state == LOAD;
  assign out_core_Rst_N = run;
  assign out_inst = (run && i_ok) ? i_rdata : NOP;
  assign out_DM_data = (run && d_ok) ? d_rdata : '0;
  // CLEAR borrows the DMEM write port to zero the array.
  assign d_we = clearing || (run && in_DM_wr_en && d_ok);
  assign d_waddr = clearing ? clr_ptr : d_off[3 +: DAW];
  assign d_wdata = clearing ? '0 : in_wr_data;
  always_comb begin
    state_n = state;
    state_n = (clearing && clr_ptr == DAW'(DMEM_DEPTH - 1)) ? LOAD :
              (ld_acc && (in_ld_last || ld_end)) ? RUN : state;
  end
  always_ff @(posedge in_Clk) begin
    if (Rst) begin
      state <= CLEAR;
      clr_ptr <= '0;
      ld_ptr <= '0;
      out_fault <= 1'b0;
      out_fault_addr <= '0;
      out_ld_overflow <= 1'b0;
    end else begin
      state <= state_n;
      if (clearing) clr_ptr <= clr_ptr + 1'b1;
      if (ld_acc) ld_ptr <= ld_ptr + 1'b1;
      if (ld_acc && ld_end && !in_ld_last) out_ld_overflow <= 1'b1;
      if (!out_fault && (f_fetch || f_wr)) begin
        out_fault <= 1'b1;
        out_fault_addr <= f_fetch ? in_inst_addr : in_addr;
      end
    end
  end
  rv64if_sp_ram #(.W(32), .DEPTH(IMEM_DEPTH)) u_imem (
    .clk(in_Clk), .we(ld_acc), .waddr(ld_ptr), .wdata(in_ld_data),
    .raddr(in_inst_addr[2 +: IAW]), .rdata(i_rdata)
  );
  rv64if_sp_ram #(.W(64), .DEPTH(DMEM_DEPTH)) u_dmem (
    .clk(in_Clk), .we(d_we), .waddr(d_waddr), .wdata(d_wdata),
    .raddr(d_off[3 +: DAW]), .rdata(d_rdata)
  );
endmodule

// File: tb/tb_rv64if_mem_responder.sv
// tb_rv64if_mem_responder: vector table plus scripted load/reset sequences;
// a second small instance exercises loader overflow.
module tb_rv64if_mem_responder;
  localparam logic [63:0] BASE = 64'h0000_0000_0001_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, wr_en, ld_valid, ld_last;
  logic [63:0] inst_addr, addr, wr_data;
  logic [31:0] ld_data, inst;
  logic [63:0] dm_data, fault_addr;
  logic ld_ready, core_rst_n, fault, ld_ovf;
  logic b_ld_valid, b_ld_last, b_ld_ready, b_core_rst_n, b_fault, b_ld_ovf;
  logic [63:0] b_inst_addr, b_dm_data, b_fault_addr;
  logic [31:0] b_ld_data, b_inst;
  int checks = 0, failures = 0;

  rv64if_mem_responder dut (
    .in_Clk(clk), .Rst(rst), .in_inst_addr(inst_addr), .out_inst(inst),
    .in_addr(addr), .in_wr_data(wr_data), .in_DM_wr_en(wr_en), .out_DM_data(dm_data),
    .in_ld_valid(ld_valid), .in_ld_data(ld_data), .in_ld_last(ld_last),
    .out_ld_ready(ld_ready), .out_core_Rst_N(core_rst_n), .out_fault(fault),
    .out_fault_addr(fault_addr), .out_ld_overflow(ld_ovf)
  );

  rv64if_mem_responder #(.IMEM_DEPTH(4), .DMEM_DEPTH(4)) dut_b (
    .in_Clk(clk), .Rst(rst), .in_inst_addr(b_inst_addr), .out_inst(b_inst),
    .in_addr(BASE), .in_wr_data(64'h0), .in_DM_wr_en(1'b0), .out_DM_data(b_dm_data),
    .in_ld_valid(b_ld_valid), .in_ld_data(b_ld_data), .in_ld_last(b_ld_last),
    .out_ld_ready(b_ld_ready), .out_core_Rst_N(b_core_rst_n), .out_fault(b_fault),
    .out_fault_addr(b_fault_addr), .out_ld_overflow(b_ld_ovf)
  );

  typedef struct {
    logic [63:0] ia, a, wd;
    logic        we;
    logic [31:0] ei;
    logic [63:0] ed;
    logic        ef;
    logic [63:0] efa;
  } vec_t;
  typedef struct {
    logic [31:0] inst;
    logic [63:0] dm;
    logic        fault;
    logic [63:0] faddr;
  } exp_t;
  vec_t vt [11];
  exp_t sb [$];
  logic [31:0] aw [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
  logic [31:0] cw [3] = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3};
  logic [31:0] dw [5] = '{32'hD000_0000, 32'hD000_0001, 32'hD000_0002, 32'hD000_0003, 32'hD000_0004};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input int expect_n);
    int n = 0;
    while (!ld_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("clear_len", 64'(n), 64'(expect_n));
  endtask

  task automatic ld(input logic [31:0] d, input logic last, input logic gap);
    ld_valid = 1'b1;
    ld_data = d;
    ld_last = last;
    @(negedge clk);
    ld_valid = 1'b0;
    ld_last = 1'b0;
    if (gap) @(negedge clk);
  endtask

  task automatic fetch(input string name, input logic [63:0] a, input logic [31:0] exp);
    inst_addr = a;
    #1 chk(name, 64'(inst), 64'(exp));
  endtask

  initial begin
    vt[0]  = '{64'h0,    BASE,              64'h0,                 1'b0, aw[0], 64'h0,                 1'b0, 64'h0};
    vt[1]  = '{64'hC,    BASE + 64'h10,     64'hDEADBEEF_CAFEF00D, 1'b1, aw[3], 64'h0,                 1'b0, 64'h0};
    vt[2]  = '{64'h4,    BASE + 64'h10,     64'h0,                 1'b0, aw[1], 64'hDEADBEEF_CAFEF00D, 1'b0, 64'h0};
    vt[3]  = '{64'h8,    BASE + 64'hFF8,    64'h0,                 1'b0, aw[2], 64'h0,                 1'b0, 64'h0};
    vt[4]  = '{64'h0,    BASE - 64'h8,      64'h0,                 1'b0, aw[0], 64'h0,                 1'b0, 64'h0};
    vt[5]  = '{64'h0,    BASE + 64'h1000,   64'h0,                 1'b0, aw[0], 64'h0,                 1'b0, 64'h0};
    vt[6]  = '{64'h0,    BASE + 64'h4,      64'h55,                1'b1, aw[0], 64'h0,                 1'b0, 64'h0};
    vt[7]  = '{64'h0,    64'h0,             64'h66,                1'b1, aw[0], 64'h0,                 1'b1, BASE + 64'h4};
    vt[8]  = '{64'h0,    BASE,              64'h0,                 1'b0, aw[0], 64'h0,                 1'b1, BASE + 64'h4};
    vt[9]  = '{64'h1000, BASE,              64'h0,                 1'b0, NOP,   64'h0,                 1'b1, BASE + 64'h4};
    vt[10] = '{64'h2,    BASE + 64'h10,     64'h0,                 1'b0, NOP,   64'hDEADBEEF_CAFEF00D, 1'b1, BASE + 64'h4};
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; addr = BASE; inst_addr = '0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    b_ld_valid = 1'b0; b_ld_data = '0; b_ld_last = 1'b0; b_inst_addr = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 64'(ld_ready), 64'h0);
    chk("rst_core_n", 64'(core_rst_n), 64'h0);
    chk("rst_fault", 64'(fault), 64'h0);
    chk("rst_faddr", fault_addr, 64'h0);
    chk("rst_ovf", 64'(ld_ovf), 64'h0);
    chk("rst_inst_nop", 64'(inst), 64'(NOP));
    @(negedge clk);
    rst = 1'b0;
    wait_ready(512);
    for (int i = 0; i < 4; i++) ld(aw[i], i == 3, 1'b0);
    #1 chk("a_core_n", 64'(core_rst_n), 64'h1);
    for (int i = 0; i < 5; i++) begin
      b_ld_valid = 1'b1;
      b_ld_data = dw[i];
      #1 chk($sformatf("b_ready%0d", i), 64'(b_ld_ready), 64'(i < 4));
      @(negedge clk);
    end
    b_ld_valid = 1'b0;
    #1;
    chk("b_core_n", 64'(b_core_rst_n), 64'h1);
    chk("b_ovf", 64'(b_ld_ovf), 64'h1);
    b_inst_addr = 64'h0;
    #1 chk("b_inst0", 64'(b_inst), 64'(dw[0]));
    b_inst_addr = 64'hC;
    #1 chk("b_inst3", 64'(b_inst), 64'(dw[3]));
    for (int i = 0; i < 11; i++) begin
      exp_t e;
      inst_addr = vt[i].ia;
      addr = vt[i].a;
      wr_en = vt[i].we;
      wr_data = vt[i].wd;
      sb.push_back('{vt[i].ei, vt[i].ed, vt[i].ef, vt[i].efa});
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d_inst", i), 64'(inst), 64'(e.inst));
      chk($sformatf("v%0d_dm", i), dm_data, e.dm);
      chk($sformatf("v%0d_fault", i), 64'(fault), 64'(e.fault));
      chk($sformatf("v%0d_faddr", i), fault_addr, e.faddr);
      @(negedge clk);
    end
    wr_en = 1'b0; inst_addr = '0; addr = BASE;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("r1_core_n", 64'(core_rst_n), 64'h0);
    chk("r1_fault", 64'(fault), 64'h0);
    chk("r1_faddr", fault_addr, 64'h0);
    wait_ready(512);
    ld(32'hBBBB_0000, 1'b0, 1'b0);
    ld(32'hBBBB_0001, 1'b0, 1'b0);
    #1 chk("mid_core_n", 64'(core_rst_n), 64'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("r2_core_n", 64'(core_rst_n), 64'h0);
    chk("r2_ready", 64'(ld_ready), 64'h0);
    chk("r2_fault", 64'(fault), 64'h0);
    wait_ready(512);
    ld(cw[0], 1'b0, 1'b1);
    ld(cw[1], 1'b0, 1'b1);
    ld_valid = 1'b1; ld_data = cw[2]; ld_last = 1'b1;
    #1 chk("c_core_n_pre", 64'(core_rst_n), 64'h0);
    @(negedge clk);
    ld_valid = 1'b0; ld_last = 1'b0;
    #1;
    chk("c_core_n", 64'(core_rst_n), 64'h1);
    chk("c_ready", 64'(ld_ready), 64'h0);
    fetch("c_inst0", 64'h0, cw[0]);
    fetch("c_inst1", 64'h4, cw[1]);
    fetch("c_inst2", 64'h8, cw[2]);
    fetch("c_prior3", 64'hC, aw[3]);
    addr = BASE + 64'h10;
    #1 chk("c_dm_cleared", dm_data, 64'h0);
    @(negedge clk);
    ld_valid = 1'b1; ld_data = 32'hFFFF_FFFF;
    @(negedge clk);
    ld_valid = 1'b0;
    fetch("run_ld_ignored", 64'hC, aw[3]);
    inst_addr = 64'h1004; addr = 64'h8; wr_en = 1'b1; wr_data = 64'h77;
    @(negedge clk);
    wr_en = 1'b0; inst_addr = '0; addr = BASE;
    #1;
    chk("dual_fault", 64'(fault), 64'h1);
    chk("dual_faddr", fault_addr, 64'h1004);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
